// File: rtl/lsu_param.sv
// lsu_param: single-thread load/store unit with one outstanding access and a WAIT timeout
module lsu_param #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              thread_active,
   input  logic [2:0]        core_state,
   input  logic              decoded_mem_read_enable,
   input  logic              decoded_mem_write_enable,
   input  logic              barrier_active,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   input  logic [ADDR_W-1:0] imm_offset,
   output logic              mem_read_valid,
   output logic [ADDR_W-1:0] mem_read_address,
   input  logic              mem_read_ready,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              mem_write_valid,
   output logic [ADDR_W-1:0] mem_write_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic              mem_write_ready,
   output logic [2:0]        lsu_state,
   output logic [DATA_W-1:0] lsu_out,
   output logic              lsu_error
);
   typedef enum logic [2:0] {IDLE = 3'd0, REQUEST = 3'd1, WAIT = 3'd2, DONE = 3'd3, ERROR = 3'd4} state_t;
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
   localparam logic [2:0] CS_REQUEST = 3'b011;
   localparam logic [2:0] CS_UPDATE  = 3'b110;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d, out_q, out_d;
   logic              err_q, err_d;
   logic              live, start, accept;
   logic [ADDR_W-1:0] eff_addr;

   assign live     = enable && thread_active;
   assign start    = live && core_state == CS_REQUEST && !barrier_active &&
                     (decoded_mem_read_enable || decoded_mem_write_enable);
   assign eff_addr = rs[ADDR_W-1:0] + imm_offset;
   // only the channel whose valid is up can complete the access
   assign accept   = (rd_valid_q && mem_read_ready) || (wr_valid_q && mem_write_ready);

   // next-state: capture, one REQUEST cycle, WAIT for ready or timeout, hold result until UPDATE
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_valid_d = rd_valid_q;
      wr_valid_d = wr_valid_q;
      rd_addr_d  = rd_addr_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      out_d      = out_q;
      err_d      = err_q;
      if (!live) begin
         state_d    = IDLE;
         rd_valid_d = 1'b0;
         wr_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_d = REQUEST;
               if (decoded_mem_read_enable) begin
                  rd_valid_d = 1'b1;
                  rd_addr_d  = eff_addr;
               end else begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = eff_addr;
                  wr_data_d  = rt;
               end
            end
            REQUEST: begin
               state_d = WAIT;
               cnt_d   = '0;
            end
            WAIT: if (accept) begin
               state_d    = DONE;
               rd_valid_d = 1'b0;
               wr_valid_d = 1'b0;
               out_d      = rd_valid_q ? mem_read_data : out_q;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == TMAX) begin
                  state_d    = ERROR;
                  rd_valid_d = 1'b0;
                  wr_valid_d = 1'b0;
                  err_d      = 1'b1;
               end
            end
            DONE, ERROR: if (core_state == CS_UPDATE) begin
               state_d = IDLE;
               err_d   = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // state registers, cleared immediately by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
         wr_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         out_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_valid_q <= rd_valid_d;
         wr_valid_q <= wr_valid_d;
         rd_addr_q  <= rd_addr_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         out_q      <= out_d;
         err_q      <= err_d;
      end
   end

   assign mem_read_valid    = rd_valid_q;
   assign mem_read_address  = rd_addr_q;
   assign mem_write_valid   = wr_valid_q;
   assign mem_write_address = wr_addr_q;
   assign mem_write_data    = wr_data_q;
   assign lsu_state         = state_q;
   assign lsu_out           = out_q;
   assign lsu_error         = err_q;
endmodule

// File: tb/tb_lsu_param.sv
// tb_lsu_param: random and directed checks of lsu_param against a transaction-level model
module tb_lsu_param;
   localparam int DW = 16;
   localparam int AW = 12;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable, thread_active, barrier_active, ld, st, rr, wr;
   logic [2:0]    core_state;
   logic [DW-1:0] rs, rt, rdata;
   logic [AW-1:0] imm;
   logic          rv, wv, err;
   logic [AW-1:0] ra, wa;
   logic [DW-1:0] wd, out;
   logic [2:0]    lstate;

   int total = 0;
   int bad = 0;

   bit            m_live, m_load, m_fin, m_errst, m_eflag;
   int            m_age, m_wait;
   logic [AW-1:0] m_ra, m_wa;
   logic [DW-1:0] m_wd, m_out;

   lsu_param #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .enable(enable), .thread_active(thread_active),
      .core_state(core_state), .decoded_mem_read_enable(ld), .decoded_mem_write_enable(st),
      .barrier_active(barrier_active), .rs(rs), .rt(rt), .imm_offset(imm),
      .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr), .mem_read_data(rdata),
      .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr),
      .lsu_state(lstate), .lsu_out(out), .lsu_error(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_live = 0; m_load = 0; m_fin = 0; m_errst = 0; m_eflag = 0;
      m_age = 0; m_wait = 0; m_ra = '0; m_wa = '0; m_wd = '0; m_out = '0;
   endtask

   // one clock edge of the reference: an access is alive for one request cycle
   // plus up to TO waiting cycles, then sits finished or failed until UPDATE
   task automatic model_step();
      int ea;
      if (reset) model_reset();
      else if (!enable || !thread_active) begin
         m_live = 0; m_fin = 0; m_errst = 0;
      end else if (m_live) begin
         if (m_age == 0) begin
            m_age = 1; m_wait = 0;
         end else if (m_load ? rr : wr) begin
            m_live = 0; m_fin = 1;
            if (m_load) m_out = rdata;
         end else begin
            m_wait++;
            if (TO != 0 && m_wait >= TO) begin
               m_live = 0; m_errst = 1; m_eflag = 1;
            end
         end
      end else if (m_fin || m_errst) begin
         if (core_state == 3'b110) begin
            m_fin = 0; m_errst = 0; m_eflag = 0;
         end
      end else if (core_state == 3'b011 && !barrier_active && (ld || st)) begin
         ea = (int'(rs) % (1 << AW) + int'(imm)) % (1 << AW);
         m_live = 1; m_age = 0; m_load = ld;
         if (ld) m_ra = ea[AW-1:0];
         else begin
            m_wa = ea[AW-1:0]; m_wd = rt;
         end
      end
   endtask

   task automatic check_all();
      int es;
      es = m_fin ? 3 : m_errst ? 4 : m_live ? (m_age == 0 ? 1 : 2) : 0;
      chk("state", 32'(lstate), 32'(es));
      chk("rvalid", 32'(rv), 32'(m_live && m_load));
      chk("wvalid", 32'(wv), 32'(m_live && !m_load));
      chk("raddr", 32'(ra), 32'(m_ra));
      chk("waddr", 32'(wa), 32'(m_wa));
      chk("wdata", 32'(wd), 32'(m_wd));
      chk("lsu_out", 32'(out), 32'(m_out));
      chk("lsu_error", 32'(err), 32'(m_eflag));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic rnd();
      int p;
      enable         = $urandom_range(0, 29) != 0;
      thread_active  = $urandom_range(0, 29) != 0;
      barrier_active = $urandom_range(0, 4) == 0;
      ld             = $urandom_range(0, 1) == 1;
      st             = $urandom_range(0, 1) == 1;
      rr             = $urandom_range(0, 3) == 0;
      wr             = $urandom_range(0, 3) == 0;
      p              = $urandom_range(0, 9);
      core_state     = p < 4 ? 3'b011 : p < 7 ? 3'b110 : 3'($urandom);
      rs             = DW'($urandom);
      rt             = DW'($urandom);
      imm            = AW'($urandom);
      rdata          = DW'($urandom);
   endtask

   initial begin
      enable = 0; thread_active = 0; barrier_active = 0; ld = 0; st = 0; rr = 0; wr = 0;
      core_state = 3'b000; rs = '0; rt = '0; imm = '0; rdata = '0;
      model_reset();
      #1;
      check_all();
      cyc();
      reset = 0;
      enable = 1; thread_active = 1;
      // load wrapping around the address space, ready after two WAIT cycles
      core_state = 3'b011; ld = 1; rs = 16'h0FFF; imm = 12'h001;
      cyc();
      ld = 0; core_state = 3'b000;
      cyc();
      cyc();
      cyc();
      rr = 1; rdata = 16'hBEEF;
      cyc();
      rr = 0;
      chk("dir_load_addr", 32'(ra), 32'h0);
      chk("dir_load_data", 32'(out), 32'hBEEF);
      core_state = 3'b110;
      cyc();
      // barrier blocks, then load+store decodes as a load
      core_state = 3'b011; ld = 1; st = 1; barrier_active = 1; rs = 16'h0010; imm = 12'h005;
      cyc();
      chk("dir_barrier", 32'(rv | wv), 32'h0);
      barrier_active = 0;
      cyc();
      chk("dir_ldst_wvalid", 32'(wv), 32'h0);
      chk("dir_ldst_raddr", 32'(ra), 32'h015);
      ld = 0; st = 0; core_state = 3'b000; wr = 1;
      // write ready on the wrong channel, then timeout
      repeat (5) cyc();
      wr = 0;
      chk("dir_timeout_err", 32'(err), 32'h1);
      core_state = 3'b110;
      cyc();
      // store with wrap, held until accepted
      core_state = 3'b011; st = 1; rs = 16'h0FFE; imm = 12'h003; rt = 16'h3C3C;
      cyc();
      st = 0; core_state = 3'b000;
      repeat (3) cyc();
      chk("dir_store_addr", 32'(wa), 32'h001);
      wr = 1;
      cyc();
      wr = 0;
      core_state = 3'b110;
      cyc();
      // async reset between edges in WAIT
      core_state = 3'b011; ld = 1;
      cyc();
      ld = 0; core_state = 3'b000;
      cyc();
      cyc();
      #3 reset = 1;
      #1;
      model_reset();
      check_all();
      cyc();
      reset = 0;
      // enable drop in WAIT
      core_state = 3'b011; ld = 1;
      cyc();
      ld = 0;
      cyc();
      enable = 0;
      cyc();
      enable = 1;
      for (int i = 0; i < 3000; i++) begin
         rnd();
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
